// File: rtl/regfile_wr_sched_pkg.sv
// Shared defaults, state encoding and sweep constants for the register-file write scheduler.
package regfile_wr_sched_pkg;

   localparam int unsigned NUM_REQ_DEFAULT = 3;
   localparam int unsigned AW_DEFAULT      = 5;
   localparam int unsigned DW_DEFAULT      = 32;
   localparam int unsigned NUM_REGS        = 32;
   localparam int unsigned CLR_CW          = $clog2(NUM_REGS);

   typedef enum logic {
      StArb   = 1'b0,
      StClear = 1'b1
   } state_e;

endpackage

// File: rtl/regfile_wr_sched_if.sv
// Multi-requester write request bus: packed valid/addr/data per requester, one-hot ready back.
interface regfile_wr_sched_if
   import regfile_wr_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
   parameter int unsigned AW      = AW_DEFAULT,
   parameter int unsigned DW      = DW_DEFAULT
) ();

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*AW-1:0] req_addr;
   logic [NUM_REQ*DW-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;

   modport master (
      output req_valid,
      output req_addr,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_data,
      output req_ready
   );

endinterface

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// Round-robin grant: first requester at or after pointer, wrapping, one-hot result.
module rr_arbiter #(
   parameter int unsigned N  = 3,
   parameter int unsigned PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] pointer,
   output logic [N-1:0]  grant
);

   int unsigned idx;
   logic        found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(pointer) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wr_sched.sv
// Arbitrates requester writes into one registered write port and runs a 32-entry zeroing sweep.
module regfile_wr_sched
   import regfile_wr_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
   parameter int unsigned AW      = AW_DEFAULT,
   parameter int unsigned DW      = DW_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   regfile_wr_sched_if.slave   req_if,
   input  logic                clear_start,
   output logic                clear_busy,
   output logic                rf_we,
   output logic [AW-1:0]       rf_waddr,
   output logic [DW-1:0]       rf_wdata
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CLR_CW-1:0] CLR_LAST = CLR_CW'(NUM_REGS - 1);

   state_e              state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [CLR_CW-1:0]   cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [AW-1:0]       waddr_q, waddr_d;
   logic [DW-1:0]       wdata_q, wdata_d;

   logic [NUM_REQ-1:0]  grant;
   logic [NUM_REQ-1:0]  ready;
   logic [PW-1:0]       gnt_idx;
   logic [AW-1:0]       gnt_addr;
   logic [DW-1:0]       gnt_data;

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_rr_arbiter (
      .req     (req_if.req_valid),
      .pointer (ptr_q),
      .grant   (grant)
   );

   // clear_start wins over any same-cycle request; nothing is granted while in reset.
   always_comb begin
      ready = '0;
      if (rst_n && (state_q == StArb) && !clear_start) ready = grant;
   end

   assign req_if.req_ready = ready;

   always_comb begin
      gnt_idx  = '0;
      gnt_addr = '0;
      gnt_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (ready[i]) begin
            gnt_idx  = PW'(i);
            gnt_addr = req_if.req_addr[i*AW +: AW];
            gnt_data = req_if.req_data[i*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      case (state_q)
         StArb: begin
            if (clear_start) begin
               // First sweep write is issued on the entry edge so busy and writes line up.
               state_d = StClear;
               cnt_d   = '0;
               we_d    = 1'b1;
               waddr_d = '0;
               wdata_d = '0;
            end else if (|ready) begin
               ptr_d = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
               if (gnt_addr != '0) begin
                  we_d    = 1'b1;
                  waddr_d = gnt_addr;
                  wdata_d = gnt_data;
               end
            end
         end
         StClear: begin
            if (cnt_q == CLR_LAST) begin
               state_d = StArb;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               we_d    = 1'b1;
               waddr_d = AW'(cnt_q + 1'b1);
               wdata_d = '0;
            end
         end
         default: state_d = StArb;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StArb;
         ptr_q   <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign clear_busy = (state_q == StClear);
   assign rf_we      = we_q;
   assign rf_waddr   = waddr_q;
   assign rf_wdata   = wdata_q;

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench: vector table for arbitration/writes plus hand sequences for clear sweeps and reset.
module tb_regfile_wr_sched;

   logic        clk;
   logic        rst_n;
   logic        clear_start;
   logic        clear_busy;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int checks;
   int errors;

   regfile_wr_sched_if #(.NUM_REQ(3), .AW(5), .DW(32)) bus ();

   regfile_wr_sched #(
      .NUM_REQ (3),
      .AW      (5),
      .DW      (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_if      (bus),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  valid;
      logic [4:0]  a0, a1, a2;
      logic [31:0] d0, d1, d2;
      logic [2:0]  exp_ready;
      logic        exp_we;
      logic [4:0]  exp_waddr;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs[9];

   function automatic vec_t mk(input logic [2:0] v, input logic [4:0] a0, input logic [31:0] d0,
                               input logic [4:0] a1, input logic [31:0] d1, input logic [4:0] a2,
                               input logic [31:0] d2, input logic [2:0] er, input logic ew,
                               input logic [4:0] ea, input logic [31:0] ed);
      vec_t r;
      r.valid = v; r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1; r.a2 = a2; r.d2 = d2;
      r.exp_ready = er; r.exp_we = ew; r.exp_waddr = ea; r.exp_wdata = ed;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1, input logic [4:0] a2,
                        input logic [31:0] d2);
      bus.req_valid = v;
      bus.req_addr  = {a2, a1, a0};
      bus.req_data  = {d2, d1, d0};
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      clear_start = 1'b0;
      drive(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int writes, busy_cnt, last_addr, seq_bad;
      logic hit;
      checks = 0;
      errors = 0;

      vecs[0] = mk(3'b010, 5'd4, 32'hAAAA, 5'd5, 32'hDEADBEEF, 5'd6, 32'hBBBB,
                   3'b010, 1'b1, 5'd5, 32'hDEADBEEF);
      vecs[1] = mk(3'b000, 5'd4, 32'hAAAA, 5'd5, 32'h1234, 5'd6, 32'hBBBB,
                   3'b000, 1'b0, 5'd5, 32'hDEADBEEF);
      vecs[2] = mk(3'b011, 5'd3, 32'h11, 5'd8, 32'h12, 5'd0, 32'h0,
                   3'b001, 1'b1, 5'd3, 32'h11);
      vecs[3] = mk(3'b111, 5'd2, 32'h21, 5'd7, 32'h22, 5'd12, 32'h23,
                   3'b010, 1'b1, 5'd7, 32'h22);
      vecs[4] = mk(3'b111, 5'd2, 32'h31, 5'd7, 32'h32, 5'd9, 32'h33,
                   3'b100, 1'b1, 5'd9, 32'h33);
      vecs[5] = mk(3'b001, 5'd0, 32'h1, 5'd7, 32'h32, 5'd9, 32'h34,
                   3'b001, 1'b0, 5'd9, 32'h33);
      vecs[6] = mk(3'b101, 5'd13, 32'h41, 5'd7, 32'h42, 5'd31, 32'h44,
                   3'b100, 1'b1, 5'd31, 32'h44);
      vecs[7] = mk(3'b110, 5'd13, 32'h51, 5'd1, 32'h55, 5'd14, 32'h56,
                   3'b010, 1'b1, 5'd1, 32'h55);
      vecs[8] = mk(3'b111, 5'd15, 32'h61, 5'd16, 32'h62, 5'd17, 32'h63,
                   3'b100, 1'b1, 5'd17, 32'h63);

      // Reset state, with requests pending to show ready is held low in reset.
      rst_n       = 1'b1;
      clear_start = 1'b0;
      drive(3'b111, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h3);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_we", 64'(rf_we), 64'd0);
      chk("rst_waddr", 64'(rf_waddr), 64'd0);
      chk("rst_wdata", 64'(rf_wdata), 64'd0);
      chk("rst_busy", 64'(clear_busy), 64'd0);
      do_reset();

      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         drive(vecs[i].valid, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1,
               vecs[i].a2, vecs[i].d2);
         #1;
         chk($sformatf("vec%0d_ready", i), 64'(bus.req_ready), 64'(vecs[i].exp_ready));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_we", i), 64'(rf_we), 64'(vecs[i].exp_we));
         chk($sformatf("vec%0d_waddr", i), 64'(rf_waddr), 64'(vecs[i].exp_waddr));
         chk($sformatf("vec%0d_wdata", i), 64'(rf_wdata), 64'(vecs[i].exp_wdata));
      end

      // Fairness from reset: all three requesting.
      do_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         drive(3'b111, 5'd1, 32'h100, 5'd2, 32'h200, 5'd3, 32'h300);
         #1;
         chk($sformatf("fair%0d_ready", c), 64'(bus.req_ready), 64'(3'b001 << (c % 3)));
         @(posedge clk);
         #1;
         chk($sformatf("fair%0d_we", c), 64'(rf_we), 64'd1);
         chk($sformatf("fair%0d_waddr", c), 64'(rf_waddr), 64'((c % 3) + 1));
         chk($sformatf("fair%0d_wdata", c), 64'(rf_wdata), 64'(((c % 3) + 1) * 256));
      end

      // Clear colliding with requests; pointer is back at 0.
      @(negedge clk);
      clear_start = 1'b1;
      #1;
      chk("clr_ready_collide", 64'(bus.req_ready), 64'd0);
      chk("clr_busy_pre", 64'(clear_busy), 64'd0);
      @(negedge clk);
      clear_start = 1'b0;
      busy_cnt = 0;
      for (int k = 0; k < 32; k++) begin
         #1;
         if (clear_busy) busy_cnt++;
         chk($sformatf("clr%0d_we", k), 64'(rf_we), 64'd1);
         chk($sformatf("clr%0d_waddr", k), 64'(rf_waddr), 64'(k));
         chk($sformatf("clr%0d_wdata", k), 64'(rf_wdata), 64'd0);
         chk($sformatf("clr%0d_ready", k), 64'(bus.req_ready), 64'd0);
         @(negedge clk);
      end
      #1;
      chk("clr_busy_cycles", 64'(busy_cnt), 64'd32);
      chk("clr_busy_after", 64'(clear_busy), 64'd0);
      chk("clr_we_after", 64'(rf_we), 64'd0);
      chk("clr_ready_after", 64'(bus.req_ready), 64'b001);

      // Reset asserted at sweep address 10.
      do_reset();
      @(negedge clk);
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
         #1;
         if (rf_we && rf_waddr == 5'd10) hit = 1'b1;
         else @(negedge clk);
      end
      chk("rstmid_reached10", 64'(hit), 64'd1);
      drive(3'b111, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h3);
      rst_n = 1'b0;
      #1;
      chk("rstmid_we", 64'(rf_we), 64'd0);
      chk("rstmid_busy", 64'(clear_busy), 64'd0);
      chk("rstmid_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
      writes = 0;
      busy_cnt = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         #1;
         if (rf_we) writes++;
         if (clear_busy) busy_cnt++;
      end
      chk("rstmid_no_writes", 64'(writes), 64'd0);
      chk("rstmid_no_busy", 64'(busy_cnt), 64'd0);
      drive(3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'd6, 32'h66);
      #1;
      chk("rstmid_arb_ready", 64'(bus.req_ready), 64'b100);

      // clear_start re-pulsed at sweep address 20 must not restart the sweep.
      do_reset();
      @(negedge clk);
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      writes = 0;
      busy_cnt = 0;
      last_addr = -1;
      seq_bad = 0;
      for (int k = 0; k < 45; k++) begin
         #1;
         clear_start = 1'b0;
         if (clear_busy) busy_cnt++;
         if (rf_we) begin
            if (int'(rf_waddr) != writes) seq_bad++;
            writes++;
            last_addr = int'(rf_waddr);
            if (rf_waddr == 5'd20) clear_start = 1'b1;
         end
         @(negedge clk);
      end
      clear_start = 1'b0;
      chk("repulse_writes", 64'(writes), 64'd32);
      chk("repulse_busy", 64'(busy_cnt), 64'd32);
      chk("repulse_last", 64'(last_addr), 64'd31);
      chk("repulse_seq", 64'(seq_bad), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_wr_sched.md
REGFILE_WR_SCHED -- requirements
Module: regfile_wr_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of write requesters.
REQ-002 SHALL have parameter AW, default 5, register address width (32 registers).
REQ-003 SHALL have parameter DW, default 32, register data width.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all scheduler state.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-007 SHALL have port req_addr  input  NUM_REQ*AW  per-requester destination register; requester i uses slice [i*AW +: AW].
REQ-008 SHALL have port req_data  input  NUM_REQ*DW  per-requester write data; requester i uses slice [i*DW +: DW].
REQ-009 SHALL have port req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when valid&ready are both high on a rising edge.
REQ-010 SHALL have port clear_start  input  1  one-cycle pulse that requests zeroing of all registers.
REQ-011 SHALL have port clear_busy  output  1  high while a clear sweep is in progress.
REQ-012 SHALL have port rf_we  output  1  register-file write enable, registered.
REQ-013 SHALL have port rf_waddr  output  AW  register-file write address, registered.
REQ-014 SHALL have port rf_wdata  output  DW  register-file write data, registered.

Function
REQ-015 SHALL implement FSM states ARB and CLEAR; reset state is ARB.
REQ-016 In ARB, req_ready SHALL be combinational: at most one bit high, selecting the first valid requester at or after the round-robin pointer (wrapping NUM_REQ-1 to 0).
REQ-017 Round-robin pointer SHALL advance to granted index+1 (mod NUM_REQ) only on a completed transfer; otherwise it holds.
REQ-018 Transfer accepted at edge N SHALL appear as a one-cycle pulse rf_we=1 with the captured addr/data in cycle N..N+1; rf_we SHALL be 0 in any cycle with no preceding transfer.
REQ-019 Transfer with address 0 SHALL be accepted (ready asserted, pointer advances) but SHALL produce rf_we=0 (r0 is read-only zero).
REQ-020 rf_waddr/rf_wdata SHALL hold last value when rf_we=0.
REQ-021 Sustained throughput SHALL be one write per clock.
REQ-022 clear_start in ARB SHALL move to CLEAR at the next edge, overriding any same-cycle request: req_ready SHALL be 0 in that cycle.
REQ-023 In CLEAR, req_ready SHALL be all-zero; the sweep SHALL drive rf_we=1, rf_wdata=0, rf_waddr=0,1,...,31 on 32 consecutive cycles, then return to ARB.
REQ-024 clear_busy SHALL be high from the cycle after clear_start through the cycle in which rf_waddr=31 is driven, and low otherwise.
REQ-025 clear_start while in CLEAR SHALL be ignored; the sweep SHALL NOT restart.
REQ-026 Outputs SHALL be stable from rising edge through the following falling edge, so a negedge-writing register file captures them.

Reset
REQ-027 On rst_n=0: state=ARB, pointer=0, rf_we=0, rf_waddr=0, rf_wdata=0, clear_busy=0, clear counter=0; req_ready SHALL be 0 while rst_n=0.
REQ-028 Reset asserted mid-sweep SHALL abort CLEAR immediately; no further clear writes after deassertion.

Structure
REQ-029 Shared package SHALL hold NUM_REQ/AW/DW defaults, the state encoding (ARB, CLEAR) and the register count constant 32.
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, pointer; output one-hot grant).

Verification
REQ-031 Single request: req_valid=3'b010, addr=5, data=32'hDEADBEEF -> ready=3'b010 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF.
REQ-032 Fairness: all three valid for 6 cycles from reset -> grants 0,1,2,0,1,2; rf_we high on 6 consecutive cycles.
REQ-033 r0 drop: requester 0 addr=0, data=32'h1 -> ready=3'b001, following cycle rf_we=0, pointer advances to 1.
REQ-034 Clear collision: clear_start with req_valid=3'b111 -> ready=0; 32 cycles of rf_we=1, data 0, addr 0..31; clear_busy high exactly 32 cycles; then requester at pointer granted.
REQ-035 Reset at sweep address 10 -> rf_we=0 immediately, clear_busy=0, state ARB after release, no writes to addr 11..31.
REQ-036 clear_start re-pulsed at sweep address 20 -> sweep ends at address 31 with no restart.
